line_buffer_array: RTL

Parametrised rolling line buffer for the streaming image path. It sits between the UART pixel receiver and the window/convolution stage. Each accepted pixel is stored into a ring of `N_LINES-1` line RAMs. For every pixel, the block emits one vertical column of `N_LINES` pixels: the incoming pixel plus the same column from each of the previous lines. This gives the downstream stage an `N_LINES`-tall window source with no further buffering.

---
 rtl/line_buffer_array.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/line_buffer_array.sv
// line_buffer_array: rolling ring of N_LINES-1 line RAMs emitting pixel columns.
// Option LINE_BUFFER_ZERO_FILL_EN: emit from first pixel, rows above frame read 0.
module line_buffer_array #(
   parameter int D_BITS   = 8,
   parameter int N_LINES  = 7,
   parameter int LINE_LEN = 640,
   parameter int ROW_BITS = 16
) (
   input  logic                        i_clk,
   input  logic                        reset,
   input  logic                        i_drdy,
   input  logic                        i_sof,
   input  logic [D_BITS-1:0]           i_data,
   output logic                        o_dvalid,
   output logic [N_LINES*D_BITS-1:0]   o_data,
   output logic [$clog2(LINE_LEN)-1:0] o_col,
   output logic [ROW_BITS-1:0]         o_row,
   output logic                        o_eol,
   output logic                        o_primed
);

   localparam int N_RAM = N_LINES - 1;
   localparam int CW    = $clog2(LINE_LEN);
   localparam int PW    = (N_RAM > 1) ? $clog2(N_RAM) : 1;
   localparam logic [CW-1:0] LAST = CW'(LINE_LEN - 1);
   localparam logic [PW-1:0] PLAST = PW'(N_RAM - 1);
   localparam logic [ROW_BITS-1:0] FILL_ROW = ROW_BITS'(N_LINES - 2);

   typedef enum logic {FILL, RUN} state_t;

   state_t              state, cur_state;
   logic [CW-1:0]       col, cur_col;
   logic [PW-1:0]       wr_ptr, cur_ptr;
   logic [ROW_BITS-1:0] row, cur_row;
   logic                emit;

   logic                s1_valid;
   logic [D_BITS-1:0]   s1_pix;
   logic [CW-1:0]       s1_col;
   logic [ROW_BITS-1:0] s1_row;
   logic                s1_eol;
   logic [PW-1:0]       s1_ptr;

   logic [N_RAM*D_BITS-1:0]   rd_all;
   logic [N_LINES*D_BITS-1:0] col_data;
   int                        idx;

   // Start of frame overrides the counters for the pixel presented with it
   always_comb begin
      cur_col   = i_sof ? '0 : col;
      cur_ptr   = i_sof ? '0 : wr_ptr;
      cur_row   = i_sof ? '0 : row;
      cur_state = i_sof ? FILL : state;
   end

`ifdef LINE_BUFFER_ZERO_FILL_EN
   assign emit = i_drdy;
`else
   assign emit = i_drdy && (cur_state == RUN);
`endif

   // Position counters and FILL/RUN state machine
   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         state    <= FILL;
         col      <= '0;
         wr_ptr   <= '0;
         row      <= '0;
         o_primed <= 1'b0;
      end else begin
         o_primed <= (state == RUN);
         if (i_drdy) begin
            if (cur_col == LAST) begin
               col    <= '0;
               wr_ptr <= (cur_ptr == PLAST) ? '0 : cur_ptr + PW'(1);
               row    <= (&cur_row) ? cur_row : cur_row + ROW_BITS'(1);
               if (cur_state == FILL && cur_row == FILL_ROW)
                  state <= RUN;
               else
                  state <= cur_state;
            end else begin
               col    <= cur_col + CW'(1);
               wr_ptr <= cur_ptr;
               row    <= cur_row;
               state  <= cur_state;
            end
         end else if (i_sof) begin
            col    <= '0;
            wr_ptr <= '0;
            row    <= '0;
            state  <= FILL;
         end
      end
   end

   for (genvar g = 0; g < N_RAM; g++) begin : g_ram
      logic [D_BITS-1:0] mem [LINE_LEN];
      logic [D_BITS-1:0] rd_q;
      // Read-first line RAM; oldest line is overwritten in place
      always_ff @(posedge i_clk) begin
         if (i_drdy) begin
            rd_q <= mem[cur_col];
            if (cur_ptr == PW'(g))
               mem[cur_col] <= i_data;
         end
      end
      assign rd_all[g*D_BITS +: D_BITS] = rd_q;
   end

   // Stage 1: capture pixel and position alongside the RAM read
   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_pix   <= '0;
         s1_col   <= '0;
         s1_row   <= '0;
         s1_eol   <= 1'b0;
         s1_ptr   <= '0;
      end else begin
         s1_valid <= emit;
         if (i_drdy) begin
            s1_pix <= i_data;
            s1_col <= cur_col;
            s1_row <= cur_row;
            s1_eol <= (cur_col == LAST);
            s1_ptr <= cur_ptr;
         end
      end
   end

   // Order RAM outputs by age relative to the write pointer
   always_comb begin
      idx      = 0;
      col_data = '0;
      col_data[D_BITS-1:0] = s1_pix;
      for (int k = 1; k < N_LINES; k++) begin
         idx = (int'(s1_ptr) + N_RAM - k) % N_RAM;
         col_data[k*D_BITS +: D_BITS] = rd_all[idx*D_BITS +: D_BITS];
`ifdef LINE_BUFFER_ZERO_FILL_EN
         if (s1_row < ROW_BITS'(k))
            col_data[k*D_BITS +: D_BITS] = '0;
`endif
      end
   end

   // Stage 2: registered column outputs
   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         o_dvalid <= 1'b0;
         o_data   <= '0;
         o_col    <= '0;
         o_row    <= '0;
         o_eol    <= 1'b0;
      end else begin
         o_dvalid <= s1_valid;
         o_eol    <= s1_valid & s1_eol;
         if (s1_valid) begin
            o_data <= col_data;
            o_col  <= s1_col;
            o_row  <= s1_row;
         end
      end
   end

endmodule
